// File: rtl/td4_core.sv
// TD4 control/datapath core: FETCH/EXEC sequencer, registers A/B/OUT/PC/CFLAG,
// initiator of an external adder ALU. One instruction retires every two clocks.
//
// state  | meaning
// FETCH  | latch IMEM_DATA into IR; no architectural change
// EXEC   | ALU operands from IR; writeback, CFLAG and PC update on closing edge
module td4_core #(
  parameter int bitWidth  = 4,
  parameter int addrWidth = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  output logic [addrWidth-1:0] IMEM_ADDR,
  input  logic [7:0]           IMEM_DATA,
  input  logic [bitWidth-1:0]  IN,
  output logic [bitWidth-1:0]  OUT,
  output logic [bitWidth-1:0]  ALU_A,
  output logic [bitWidth-1:0]  ALU_B,
  input  logic [bitWidth-1:0]  ALU_Y,
  input  logic                 ALU_C,
  output logic                 CFLAG,
  output logic                 RETIRE
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  state_t               state;
  logic [addrWidth-1:0] pc;
  logic [7:0]           ir;
  logic [bitWidth-1:0]  reg_a;
  logic [bitWidth-1:0]  reg_b;
  logic [bitWidth-1:0]  reg_out;
  logic                 cflag;
  logic                 retire;

  logic [3:0]           opcode;
  logic [bitWidth-1:0]  src_sel;
  logic                 wr_a;
  logic                 wr_b;
  logic                 wr_out;
  logic                 jump;
  logic                 defined_op;

  assign opcode    = ir[7:4];
  assign IMEM_ADDR = pc;
  assign OUT       = reg_out;
  assign CFLAG     = cflag;
  assign RETIRE    = retire;
  assign ALU_A     = src_sel;
  assign ALU_B     = bitWidth'(ir[3:0]);

  always_comb begin
    src_sel    = '0;
    wr_a       = 1'b0;
    wr_b       = 1'b0;
    wr_out     = 1'b0;
    jump       = 1'b0;
    defined_op = 1'b1;
    case (opcode)
      4'b0000: begin src_sel = reg_a; wr_a = 1'b1; end
      4'b0011: begin                  wr_a = 1'b1; end
      4'b0001: begin src_sel = reg_b; wr_a = 1'b1; end
      4'b0010: begin src_sel = IN;    wr_a = 1'b1; end
      4'b0101: begin src_sel = reg_b; wr_b = 1'b1; end
      4'b0111: begin                  wr_b = 1'b1; end
      4'b0100: begin src_sel = reg_a; wr_b = 1'b1; end
      4'b0110: begin src_sel = IN;    wr_b = 1'b1; end
      4'b1001: begin src_sel = reg_b; wr_out = 1'b1; end
      4'b1011: begin                  wr_out = 1'b1; end
      4'b1111: jump = 1'b1;
      // JNC tests the flag left by the previous instruction
      4'b1110: jump = ~cflag;
      default: defined_op = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_FETCH;
      pc      <= '0;
      ir      <= '0;
      reg_a   <= '0;
      reg_b   <= '0;
      reg_out <= '0;
      cflag   <= 1'b0;
      retire  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          ir     <= IMEM_DATA;
          state  <= S_EXEC;
          retire <= 1'b1;
        end
        S_EXEC: begin
          if (wr_a)   reg_a   <= ALU_Y;
          if (wr_b)   reg_b   <= ALU_Y;
          if (wr_out) reg_out <= ALU_Y;
          cflag  <= defined_op & ALU_C;
          pc     <= jump ? addrWidth'(ALU_Y) : pc + 1'b1;
          state  <= S_FETCH;
          retire <= 1'b0;
        end
        default: begin
          state  <= S_FETCH;
          retire <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_td4_core.sv
// Scoreboard bench for td4_core: directed ROM programs, expected EXEC-cycle
// observations queued by the stimulus and checked by an independent monitor.
module tb_td4_core;

  logic       CLK;
  logic       RST;
  logic [3:0] IMEM_ADDR;
  logic [7:0] IMEM_DATA;
  logic [3:0] IN;
  logic [3:0] OUT;
  logic [3:0] ALU_A;
  logic [3:0] ALU_B;
  logic [3:0] ALU_Y;
  logic       ALU_C;
  logic       CFLAG;
  logic       RETIRE;

  logic [7:0] rom [16];

  typedef struct {
    logic [3:0] pc;
    logic [3:0] a;
    logic [3:0] b;
    logic       cf;
    logic [3:0] out;
    bit         chk_a;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  td4_core #(.bitWidth(4), .addrWidth(4)) dut (
    .CLK(CLK), .RST(RST), .IMEM_ADDR(IMEM_ADDR), .IMEM_DATA(IMEM_DATA),
    .IN(IN), .OUT(OUT), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Y(ALU_Y),
    .ALU_C(ALU_C), .CFLAG(CFLAG), .RETIRE(RETIRE)
  );

  // external ALU: 4-bit adder with carry-out
  assign {ALU_C, ALU_Y} = {1'b0, ALU_A} + {1'b0, ALU_B};
  assign IMEM_DATA = rom[IMEM_ADDR];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] pc, input logic [3:0] a, input logic [3:0] b,
                      input logic cf, input logic [3:0] out, input bit chk_a = 1'b1);
    exp_t e;
    e.pc = pc; e.a = a; e.b = b; e.cf = cf; e.out = out; e.chk_a = chk_a;
    exp_q.push_back(e);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
  endtask

  always @(negedge CLK) begin
    if (!RST && RETIRE && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("exec_pc", {4'h0, IMEM_ADDR}, {4'h0, mon_e.pc});
      if (mon_e.chk_a) chk("exec_alu_a", {4'h0, ALU_A}, {4'h0, mon_e.a});
      chk("exec_alu_b", {4'h0, ALU_B}, {4'h0, mon_e.b});
      chk("exec_cflag", {7'h0, CFLAG}, {7'h0, mon_e.cf});
      chk("exec_out", {4'h0, OUT}, {4'h0, mon_e.out});
    end
  end

  // Release reset, let the queued program retire, check cadence and final state.
  task automatic run_prog(input int n, input logic [3:0] pc_f, input logic cf_f,
                          input logic [3:0] out_f);
    int cycles;
    @(negedge CLK);
    RST = 1'b0;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 200) begin
      @(posedge CLK);
      cycles++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    chk("retire_cadence", 8'(cycles), 8'(2 * n));
    #1;
    chk("final_pc", {4'h0, IMEM_ADDR}, {4'h0, pc_f});
    chk("final_cflag", {7'h0, CFLAG}, {7'h0, cf_f});
    chk("final_out", {4'h0, OUT}, {4'h0, out_f});
    RST = 1'b1;
    #1;
  endtask

  initial begin
    RST = 1'b1;
    IN  = 4'h0;
    clear_rom();
    #1;
    chk("rst_pc", {4'h0, IMEM_ADDR}, 8'h00);
    chk("rst_retire", {7'h0, RETIRE}, 8'h00);
    chk("rst_cflag", {7'h0, CFLAG}, 8'h00);
    chk("rst_out", {4'h0, OUT}, 8'h00);

    // reset in the middle of ADD A,3 with A=5
    rom[0] = 8'hB7; rom[1] = 8'h35; rom[2] = 8'h03;
    push(4'd0, 4'h0, 4'h7, 1'b0, 4'h0);
    push(4'd1, 4'h0, 4'h5, 1'b0, 4'h7);
    push(4'd2, 4'h5, 4'h3, 1'b0, 4'h7);
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("midexec_pc", {4'h0, IMEM_ADDR}, 8'h00);
    chk("midexec_retire", {7'h0, RETIRE}, 8'h00);
    chk("midexec_cflag", {7'h0, CFLAG}, 8'h00);
    chk("midexec_out", {4'h0, OUT}, 8'h00);
    chk("midexec_pending", 8'(exp_q.size()), 8'h00);
    exp_q.delete();

    // after reset A and B read back as 0
    clear_rom();
    rom[0] = 8'h50; rom[1] = 8'h03; rom[2] = 8'h40; rom[3] = 8'h90;
    push(4'd0, 4'h0, 4'h0, 1'b0, 4'h0);
    push(4'd1, 4'h0, 4'h3, 1'b0, 4'h0);
    push(4'd2, 4'h3, 4'h0, 1'b0, 4'h0);
    push(4'd3, 4'h3, 4'h0, 1'b0, 4'h0);
    run_prog(4, 4'd4, 1'b0, 4'h3);

    // MOV A,5; ADD A,3; MOV B,A; OUT B
    clear_rom();
    rom[0] = 8'h35; rom[1] = 8'h03; rom[2] = 8'h40; rom[3] = 8'h90;
    push(4'd0, 4'h0, 4'h5, 1'b0, 4'h0);
    push(4'd1, 4'h5, 4'h3, 1'b0, 4'h0);
    push(4'd2, 4'h8, 4'h0, 1'b0, 4'h0);
    push(4'd3, 4'h8, 4'h0, 1'b0, 4'h0);
    run_prog(4, 4'd4, 1'b0, 4'h8);

    // carry then JNC not taken
    clear_rom();
    rom[0] = 8'h3F; rom[1] = 8'h03; rom[2] = 8'hE0; rom[3] = 8'hB7;
    rom[4] = 8'h40; rom[5] = 8'h90;
    push(4'd0, 4'h0, 4'hF, 1'b0, 4'h0);
    push(4'd1, 4'hF, 4'h3, 1'b0, 4'h0);
    push(4'd2, 4'h0, 4'h0, 1'b1, 4'h0);
    push(4'd3, 4'h0, 4'h7, 1'b0, 4'h0);
    push(4'd4, 4'h2, 4'h0, 1'b0, 4'h7);
    push(4'd5, 4'h2, 4'h0, 1'b0, 4'h7);
    run_prog(6, 4'd6, 1'b0, 4'h2);

    // JNC taken loop
    clear_rom();
    rom[0] = 8'h71; rom[1] = 8'hE0;
    for (int i = 0; i < 3; i++) begin
      push(4'd0, 4'h0, 4'h1, 1'b0, 4'h0);
      push(4'd1, 4'h0, 4'h0, 1'b0, 4'h0);
    end
    run_prog(6, 4'd0, 1'b0, 4'h0);

    // IN path, MOV A,B, carry, IN A, JMP, ADD B with carry
    clear_rom();
    IN = 4'h9;
    rom[0] = 8'h60; rom[1] = 8'h90; rom[2] = 8'h10; rom[3] = 8'h09;
    rom[4] = 8'h20; rom[5] = 8'hF8; rom[8] = 8'h57;
    push(4'd0, 4'h9, 4'h0, 1'b0, 4'h0);
    push(4'd1, 4'h9, 4'h0, 1'b0, 4'h0);
    push(4'd2, 4'h9, 4'h0, 1'b0, 4'h9);
    push(4'd3, 4'h9, 4'h9, 1'b0, 4'h9);
    push(4'd4, 4'h9, 4'h0, 1'b1, 4'h9);
    push(4'd5, 4'h0, 4'h8, 1'b0, 4'h9);
    push(4'd8, 4'h9, 4'h7, 1'b0, 4'h9);
    run_prog(7, 4'd9, 1'b1, 4'h9);
    IN = 4'h0;

    // NOP sweep (including other undefined opcodes) with PC wrap
    clear_rom();
    rom[0] = 8'hB5; rom[1] = 8'h3C; rom[2] = 8'h0B; rom[3] = 8'h83;
    for (int i = 4; i < 15; i++) rom[i] = 8'h80 | 8'(i);
    rom[5] = 8'hA5; rom[12] = 8'hCC; rom[13] = 8'hDD; rom[15] = 8'h40;
    push(4'd0, 4'h0, 4'h5, 1'b0, 4'h0);
    push(4'd1, 4'h0, 4'hC, 1'b0, 4'h5);
    push(4'd2, 4'hC, 4'hB, 1'b0, 4'h5);
    push(4'd3, 4'h0, 4'h3, 1'b1, 4'h5, 1'b0);
    for (int i = 4; i < 15; i++) push(4'(i), 4'h0, 4'(i), 1'b0, 4'h5, 1'b0);
    push(4'd15, 4'h7, 4'h0, 1'b0, 4'h5);
    run_prog(16, 4'd0, 1'b0, 4'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
